// File: rtl/srm_datapath_seq.sv
// Sequenced datapath with a register file, A/B/C regs, shifter, ALU and {N,V,Z} status; one MOV/ALU op per start/done.
// Optional debug read port enabled by defining SRM_DP_DBG_PORT_EN.
module srm_datapath_seq #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [2:0]                 op,
  input  logic [$clog2(NREGS)-1:0]   rd,
  input  logic [$clog2(NREGS)-1:0]   rn,
  input  logic [$clog2(NREGS)-1:0]   rm,
  input  logic [1:0]                 shift,
  input  logic [7:0]                 imm8,
  output logic                       ready,
  output logic                       done,
  output logic [DATA_W-1:0]          result,
  output logic [2:0]                 status
`ifdef SRM_DP_DBG_PORT_EN
  ,
  input  logic [$clog2(NREGS)-1:0]   dbg_rnum,
  output logic [DATA_W-1:0]          dbg_rdata
`endif
);

  localparam int RW = $clog2(NREGS);

  localparam logic [2:0] OP_MOV_IMM = 3'b000;
  localparam logic [2:0] OP_MOV_REG = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_CMP     = 3'b011;
  localparam logic [2:0] OP_AND     = 3'b100;
  localparam logic [2:0] OP_MVN     = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_B = 3'd1,
    S_LOAD_A = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  function automatic logic [DATA_W-1:0] sign_ext(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] shift_op(input logic [DATA_W-1:0] v, input logic [1:0] s);
    logic [DATA_W-1:0] r;
    case (s)
      2'b00:   r = v;
      2'b01:   r = {v[DATA_W-2:0], 1'b0};
      2'b10:   r = {1'b0, v[DATA_W-1:1]};
      2'b11:   r = {v[DATA_W-1], v[DATA_W-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic writes_rd(input logic [2:0] o);
    return (o == OP_MOV_IMM) || (o == OP_MOV_REG) || (o == OP_MVN) ||
           (o == OP_ADD) || (o == OP_AND);
  endfunction

  state_t              state_r, state_next_s;
  logic [2:0]          op_r;
  logic [RW-1:0]       rd_r, rn_r, rm_r;
  logic [1:0]          shift_r;
  logic [DATA_W-1:0]   regs_r [NREGS];
  logic [DATA_W-1:0]   a_r, b_r, c_r;
  logic [2:0]          status_r;
  logic                accept_s, write_en_s, arith_s;
  logic [DATA_W-1:0]   shb_s, diff_s, alu_s;
  logic                ovf_s;

  // Next-state decode, accept strobe and register-file write enable
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    write_en_s   = 1'b0;
    arith_s      = (op_r == OP_ADD) || (op_r == OP_CMP) || (op_r == OP_AND);
    case (state_r)
      S_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          case (op)
            OP_MOV_REG, OP_MVN, OP_ADD, OP_CMP, OP_AND: state_next_s = S_LOAD_B;
            default:                                    state_next_s = S_WRITE;
          endcase
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD_B: begin
        if (arith_s) begin
          state_next_s = S_LOAD_A;
        end else begin
          state_next_s = S_EXEC;
        end
      end
      S_LOAD_A: state_next_s = S_EXEC;
      S_EXEC:   state_next_s = S_WRITE;
      S_WRITE: begin
        state_next_s = S_IDLE;
        write_en_s   = writes_rd(op_r);
      end
      default:  state_next_s = S_IDLE;
    endcase
  end

  // Shifter and ALU; CMP overflow is that of A - sh(B)
  always_comb begin
    shb_s  = shift_op(b_r, shift_r);
    diff_s = a_r - shb_s;
    ovf_s  = (a_r[DATA_W-1] != shb_s[DATA_W-1]) && (diff_s[DATA_W-1] != a_r[DATA_W-1]);
    case (op_r)
      OP_MOV_REG: alu_s = shb_s;
      OP_MVN:     alu_s = ~shb_s;
      OP_ADD:     alu_s = a_r + shb_s;
      OP_CMP:     alu_s = diff_s;
      OP_AND:     alu_s = a_r & shb_s;
      default:    alu_s = c_r;
    endcase
  end

  // Sequencer state, latched instruction fields and A/B/C/status datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= S_IDLE;
      op_r     <= 3'b000;
      rd_r     <= '0;
      rn_r     <= '0;
      rm_r     <= '0;
      shift_r  <= 2'b00;
      a_r      <= '0;
      b_r      <= '0;
      c_r      <= '0;
      status_r <= 3'b000;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        op_r    <= op;
        rd_r    <= rd;
        rn_r    <= rn;
        rm_r    <= rm;
        shift_r <= shift;
        if (op == OP_MOV_IMM) begin
          c_r <= sign_ext(imm8);
        end
      end
      if (state_r == S_LOAD_B) begin
        b_r <= regs_r[rm_r];
      end
      if (state_r == S_LOAD_A) begin
        a_r <= regs_r[rn_r];
      end
      if (state_r == S_EXEC) begin
        c_r <= alu_s;
        if (op_r == OP_CMP) begin
          status_r <= {diff_s[DATA_W-1], ovf_s, (diff_s == '0)};
        end
      end
    end
  end

  // Register file; the destination is written at the edge that ends WRITE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (write_en_s) begin
      regs_r[rd_r] <= c_r;
    end
  end

  assign ready  = (state_r == S_IDLE);
  assign done   = (state_r == S_WRITE);
  assign result = c_r;
  assign status = status_r;

`ifdef SRM_DP_DBG_PORT_EN
  assign dbg_rdata = regs_r[dbg_rnum];
`endif

endmodule

// File: tb/tb_srm_datapath_seq.sv
// Directed self-checking bench for srm_datapath_seq (DATA_W=16, NREGS=8).
module tb_srm_datapath_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [2:0]  rd = 3'd0, rn = 3'd0, rm = 3'd0;
  logic [1:0]  shift = 2'b00;
  logic [7:0]  imm8 = 8'h00;
  logic        ready, done;
  logic [15:0] result;
  logic [2:0]  status;
`ifdef SRM_DP_DBG_PORT_EN
  logic [2:0]  dbg_rnum = 3'd0;
  logic [15:0] dbg_rdata;
`endif

  int errors = 0;
  int checks = 0;
  int lat;
  int pulses;
  logic [15:0] val;

  srm_datapath_seq #(.DATA_W(16), .NREGS(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .rd(rd), .rn(rn), .rm(rm),
    .shift(shift), .imm8(imm8), .ready(ready), .done(done), .result(result), .status(status)
`ifdef SRM_DP_DBG_PORT_EN
    , .dbg_rnum(dbg_rnum), .dbg_rdata(dbg_rdata)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction, scramble inputs after accept, wait (bounded) for done.
  task automatic issue(input string tag, input logic [2:0] o, input logic [2:0] d,
                       input logic [2:0] n, input logic [2:0] m, input logic [1:0] s,
                       input logic [7:0] i, input int exp_lat);
    @(negedge clk);
    op = o; rd = d; rn = n; rm = m; shift = s; imm8 = i; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'b000; rd = ~d; rn = ~n; rm = ~m; shift = ~s; imm8 = 8'h5A;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    @(negedge clk);
    chk({tag, "_ready_after"}, {done, ready}, 2'b01);
  endtask

  task automatic read_reg(input logic [2:0] n, output logic [15:0] v);
    issue("read", 3'b001, n, n, n, 2'b00, 8'h00, 3);
    v = result;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_ready_done", {ready, done}, 2'b10);
    chk("rst_result", result, 16'h0000);
    chk("rst_status", status, 3'b000);

    // 1: MOV R0,#7; MOV R1,#2; ADD R2,R1,R0,LSL1
    issue("mov_r0", 3'b000, 3'd0, 3'd0, 3'd0, 2'b00, 8'd7, 1);
    chk("mov_r0_result", result, 16'h0007);
    issue("mov_r1", 3'b000, 3'd1, 3'd0, 3'd0, 2'b00, 8'd2, 1);
    issue("add_r2", 3'b010, 3'd2, 3'd1, 3'd0, 2'b01, 8'h00, 4);
    chk("add_result", result, 16'h0010);
    chk("add_status", status, 3'b000);
    read_reg(3'd2, val);
    chk("r2_value", val, 16'h0010);

    // 2: sign-extended immediate and the two right shifts
    issue("mov_r3", 3'b000, 3'd3, 3'd0, 3'd0, 2'b00, 8'hFF, 1);
    chk("mov_r3_result", result, 16'hFFFF);
    issue("lsr", 3'b001, 3'd4, 3'd0, 3'd3, 2'b10, 8'h00, 3);
    chk("lsr_result", result, 16'h7FFF);
    issue("asr", 3'b001, 3'd5, 3'd0, 3'd3, 2'b11, 8'h00, 3);
    chk("asr_result", result, 16'hFFFF);

    // 3: CMP overflow case and zero case; no register writes
    issue("cmp1", 3'b011, 3'd0, 3'd4, 3'd3, 2'b00, 8'h00, 4);
    chk("cmp1_result", result, 16'h8000);
    chk("cmp1_status", status, 3'b110);
    read_reg(3'd0, val);
    chk("cmp1_r0_kept", val, 16'h0007);
    chk("mov_keeps_status", status, 3'b110);
    read_reg(3'd4, val);
    chk("cmp1_r4_kept", val, 16'h7FFF);
    issue("cmp2", 3'b011, 3'd1, 3'd0, 3'd0, 2'b00, 8'h00, 4);
    chk("cmp2_status", status, 3'b001);
    read_reg(3'd1, val);
    chk("cmp2_r1_kept", val, 16'h0002);

    // MVN and AND
    issue("mvn", 3'b101, 3'd6, 3'd0, 3'd1, 2'b00, 8'h00, 3);
    chk("mvn_result", result, 16'hFFFD);
    issue("and", 3'b100, 3'd7, 3'd0, 3'd1, 2'b00, 8'h00, 4);
    chk("and_result", result, 16'h0002);

    // 4: start during LOAD_A is ignored
    @(negedge clk);
    op = 3'b010; rd = 3'd2; rn = 3'd1; rm = 3'd0; shift = 2'b00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) pulses++;
      if (k == 2) begin
        op = 3'b000; rd = 3'd0; imm8 = 8'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_done_pulses", pulses, 1);
    chk("busy_add_result", result, 16'h0009);
    read_reg(3'd0, val);
    chk("busy_r0_kept", val, 16'h0007);

    // 6: -128 immediate, AND with itself, illegal op
    issue("mov_r6", 3'b000, 3'd6, 3'd0, 3'd0, 2'b00, 8'h80, 1);
    chk("mov_r6_result", result, 16'hFF80);
`ifdef SRM_DP_DBG_PORT_EN
    dbg_rnum = 3'd6;
    #1 chk("dbg_r6", dbg_rdata, 16'hFF80);
`endif
    issue("and_r7", 3'b100, 3'd7, 3'd6, 3'd6, 2'b00, 8'h00, 4);
    chk("and_r7_result", result, 16'hFF80);
`ifdef SRM_DP_DBG_PORT_EN
    dbg_rnum = 3'd7;
    #1 chk("dbg_r7", dbg_rdata, 16'hFF80);
`endif
    issue("illegal", 3'b111, 3'd7, 3'd0, 3'd0, 2'b00, 8'h11, 1);
    chk("illegal_result", result, 16'hFF80);
    chk("illegal_status", status, 3'b001);
    read_reg(3'd7, val);
    chk("illegal_r7_kept", val, 16'hFF80);

    // 5: reset during EXEC abandons the instruction
    @(negedge clk);
    op = 3'b010; rd = 3'd2; rn = 3'd1; rm = 3'd0; shift = 2'b00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done) pulses++;
      if (k == 3) begin
        reset_n = 1'b0;
      end else if (k == 4) begin
        reset_n = 1'b1;
      end else if (k == 5) begin
        chk("rst_mid_ready", ready, 1'b1);
      end
    end
    chk("rst_mid_no_done", pulses, 0);
    chk("rst_mid_result", result, 16'h0000);
    chk("rst_mid_status", status, 3'b000);
    read_reg(3'd0, val);
    chk("rst_mid_r0", val, 16'h0000);
    read_reg(3'd2, val);
    chk("rst_mid_r2", val, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
